// File: rtl/screen_fade_mux.sv
// screen_fade_mux: selects one of NUM_CH RGB332 screen sources with a frame-paced fade-out/fade-in on switch.
// Fading is enabled by defining SCREEN_FADE_EN; otherwise channel changes are immediate.
module screen_fade_mux #(
    parameter int NUM_CH     = 4,
    parameter int FADE_SHIFT = 3,
    parameter int INIT_SEL   = 0,
    localparam int SEL_W     = $clog2(NUM_CH),
    localparam int MAXB      = 2 ** FADE_SHIFT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frameStart,
    input  logic [SEL_W-1:0]    selCode,
    input  logic [NUM_CH-1:0]   drawingRequestIn,
    input  logic [NUM_CH*8-1:0] RGBin,
    output logic                drawingRequest_out,
    output logic [7:0]          RGBout,
    output logic [SEL_W-1:0]    activeSel,
    output logic                busy
);
    localparam int BW = FADE_SHIFT + 1;
    localparam logic [BW-1:0] B_MAX = BW'(MAXB);
    localparam logic [SEL_W-1:0] SEL_INIT = SEL_W'(INIT_SEL);
    localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(NUM_CH);

    logic             sel_ok;
    logic [SEL_W-1:0] active_sel;
    logic [BW-1:0]    b;
    logic [7:0]       pix;
    logic [7:0]       pix_scaled;

    assign sel_ok    = {1'b0, selCode} < CH_LIM;
    assign activeSel = active_sel;

    function automatic logic [2:0] scale(input logic [2:0] c, input logic [BW-1:0] k);
        logic [BW+2:0] p;
        p = {{BW{1'b0}}, c} * {3'b000, k};
        return 3'(p >> FADE_SHIFT);
    endfunction

    assign pix        = RGBin[{active_sel, 3'b000} +: 8];
    assign pix_scaled = {scale(pix[7:5], b), scale(pix[4:2], b), 2'(scale({1'b0, pix[1:0]}, b))};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RGBout             <= 8'h00;
            drawingRequest_out <= 1'b0;
        end else begin
            RGBout             <= pix_scaled;
            drawingRequest_out <= drawingRequestIn[active_sel];
        end
    end

`ifdef SCREEN_FADE_EN
    typedef enum logic [1:0] {IDLE, FADE_OUT, HOLD, FADE_IN} state_t;

    state_t           state, state_n;
    logic [BW-1:0]    b_n;
    logic [SEL_W-1:0] target, target_n, active_n;

    assign busy = state != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            b          <= B_MAX;
            target     <= SEL_INIT;
            active_sel <= SEL_INIT;
        end else begin
            state      <= state_n;
            b          <= b_n;
            target     <= target_n;
            active_sel <= active_n;
        end
    end

    always_comb begin
        state_n  = state;
        b_n      = b;
        target_n = target;
        active_n = active_sel;
        case (state)
            IDLE: begin
                if (sel_ok && selCode != active_sel) begin
                    target_n = selCode;
                    state_n  = FADE_OUT;
                end
            end
            FADE_OUT: begin
                target_n = sel_ok ? selCode : target;
                // A request back to the displayed channel reverses the fade in place.
                if (target_n == active_sel) state_n = FADE_IN;
                else if (frameStart) begin
                    b_n     = (b <= BW'(1)) ? '0 : b - 1'b1;
                    state_n = (b <= BW'(1)) ? HOLD : FADE_OUT;
                end
            end
            HOLD: begin
                target_n = sel_ok ? selCode : target;
                if (frameStart) begin
                    active_n = target_n;
                    b_n      = '0;
                    state_n  = FADE_IN;
                end
            end
            FADE_IN: begin
                if (frameStart) begin
                    b_n     = (b >= B_MAX - 1'b1) ? B_MAX : b + 1'b1;
                    state_n = (b >= B_MAX - 1'b1) ? IDLE : FADE_IN;
                end
            end
            default: state_n = IDLE;
        endcase
    end
`else
    logic unused_frame;

    assign unused_frame = frameStart;
    assign b            = B_MAX;
    assign busy         = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) active_sel <= SEL_INIT;
        else active_sel <= sel_ok ? selCode : active_sel;
    end
`endif
endmodule

// File: tb/tb_screen_fade_mux.sv
// tb_screen_fade_mux: directed vectors with a queue-based scoreboard; covers both SCREEN_FADE_EN builds.
module tb_screen_fade_mux;
    typedef struct {
        logic [7:0] rgb;
        logic       dr;
        logic [1:0] sel;
        logic       busy;
        logic [1:0] sel3;
        logic       busy3;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_start = 1'b0;
    logic [1:0]  sel_code = 2'd0;
    logic [1:0]  sel3 = 2'd3;
    logic [3:0]  dr_in = 4'b0110;
    logic [31:0] rgb_in = 32'h24B649FF;
    logic        dr_out, busy;
    logic [7:0]  rgb_out;
    logic [1:0]  active_sel;
    logic        unused_dr3, busy3;
    logic [7:0]  unused_rgb3;
    logic [1:0]  active3;
    logic [1:0]  e3_sel = 2'd1;
    logic        e3_busy = 1'b0;
    int          checks = 0;
    int          failures = 0;
    exp_t        q[$];

    always #5 clk = ~clk;

    screen_fade_mux #(.NUM_CH(4), .FADE_SHIFT(2), .INIT_SEL(0)) dut (
        .clk(clk), .reset(reset), .frameStart(frame_start), .selCode(sel_code),
        .drawingRequestIn(dr_in), .RGBin(rgb_in), .drawingRequest_out(dr_out),
        .RGBout(rgb_out), .activeSel(active_sel), .busy(busy)
    );

    screen_fade_mux #(.NUM_CH(3), .FADE_SHIFT(1), .INIT_SEL(1)) dut3 (
        .clk(clk), .reset(reset), .frameStart(frame_start), .selCode(sel3),
        .drawingRequestIn(3'b101), .RGBin(24'hB649FF), .drawingRequest_out(unused_dr3),
        .RGBout(unused_rgb3), .activeSel(active3), .busy(busy3)
    );

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", n, act, want, $time);
        end
    endtask

    task automatic push(input logic [7:0] e_rgb, input logic e_dr, input logic [1:0] e_sel, input logic e_busy);
        exp_t e;
        e.rgb = e_rgb;
        e.dr = e_dr;
        e.sel = e_sel;
        e.busy = e_busy;
        e.sel3 = e3_sel;
        e.busy3 = e3_busy;
        q.push_back(e);
    endtask

    task automatic step(input logic fs, input logic [1:0] sel, input logic [7:0] e_rgb,
                        input logic e_dr, input logic [1:0] e_sel, input logic e_busy);
        frame_start = fs;
        sel_code = sel;
        @(posedge clk);
        push(e_rgb, e_dr, e_sel, e_busy);
        #1 frame_start = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        #1 reset = 1'b1;
        e3_sel = 2'd1;
        e3_busy = 1'b0;
        #1 push(8'h00, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("rgb_out", rgb_out, e.rgb);
                chk("draw_req", {7'd0, dr_out}, {7'd0, e.dr});
                chk("active_sel", {6'd0, active_sel}, {6'd0, e.sel});
                chk("busy", {7'd0, busy}, {7'd0, e.busy});
                chk("active_sel_ch3", {6'd0, active3}, {6'd0, e.sel3});
                chk("busy_ch3", {7'd0, busy3}, {7'd0, e.busy3});
            end
        end
    end

    initial begin
        do_reset();
`ifdef SCREEN_FADE_EN
        step(0, 0, 8'hFF, 0, 0, 0);
        step(0, 2, 8'hFF, 0, 0, 1);
        step(1, 2, 8'hFF, 0, 0, 1);
        step(0, 2, 8'hB6, 0, 0, 1);
        step(1, 2, 8'hB6, 0, 0, 1);
        step(1, 2, 8'h6D, 0, 0, 1);
        step(1, 2, 8'h24, 0, 0, 1);
        step(0, 2, 8'h00, 0, 0, 1);
        step(1, 2, 8'h00, 0, 2, 1);
        step(0, 0, 8'h00, 1, 2, 1);
        step(1, 2, 8'h00, 1, 2, 1);
        step(1, 2, 8'h24, 1, 2, 1);
        step(1, 2, 8'h49, 1, 2, 1);
        step(1, 2, 8'h6D, 1, 2, 0);
        step(0, 2, 8'hB6, 1, 2, 0);
        // retarget 2 -> 1 -> 3 while fading out
        step(0, 1, 8'hB6, 1, 2, 1);
        step(1, 3, 8'hB6, 1, 2, 1);
        step(1, 3, 8'h6D, 1, 2, 1);
        step(1, 3, 8'h49, 1, 2, 1);
        step(1, 3, 8'h24, 1, 2, 1);
        step(1, 3, 8'h00, 1, 3, 1);
        step(1, 3, 8'h00, 0, 3, 1);
        step(1, 3, 8'h00, 0, 3, 1);
        step(1, 3, 8'h00, 0, 3, 1);
        step(1, 3, 8'h00, 0, 3, 0);
        step(0, 3, 8'h24, 0, 3, 0);
        // reset in the middle of a fade-out
        step(0, 0, 8'h24, 0, 3, 1);
        step(1, 0, 8'h24, 0, 3, 1);
        do_reset();
        step(0, 0, 8'hFF, 0, 0, 0);
        // reversal back to the displayed channel at b=2
        step(0, 1, 8'hFF, 0, 0, 1);
        step(1, 1, 8'hFF, 0, 0, 1);
        step(1, 1, 8'hB6, 0, 0, 1);
        step(0, 0, 8'h6D, 0, 0, 1);
        step(0, 0, 8'h6D, 0, 0, 1);
        step(1, 0, 8'h6D, 0, 0, 1);
        step(1, 0, 8'hB6, 0, 0, 0);
        step(0, 0, 8'hFF, 0, 0, 0);
        sel3 = 2'd0;
        e3_sel = 2'd1;
        e3_busy = 1'b1;
`else
        step(0, 0, 8'hFF, 0, 0, 0);
        step(1, 2, 8'hFF, 0, 2, 0);
        step(0, 2, 8'hB6, 1, 2, 0);
        step(0, 3, 8'hB6, 1, 3, 0);
        step(1, 3, 8'h24, 0, 3, 0);
        step(0, 1, 8'h24, 0, 1, 0);
        step(0, 1, 8'h49, 1, 1, 0);
        do_reset();
        step(0, 0, 8'hFF, 0, 0, 0);
        sel3 = 2'd0;
        e3_sel = 2'd0;
        e3_busy = 1'b0;
`endif
        step(0, 0, 8'hFF, 0, 0, 0);
        step(0, 0, 8'hFF, 0, 0, 0);
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/screen_fade_mux.md
SCREEN_FADE_MUX -- requirements
Module: screen_fade_mux

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of screen channels; legal range 2..16.
REQ-002 SHALL have parameter FADE_SHIFT, default 3, meaning fade step count = 2**FADE_SHIFT; legal range 1..4.
REQ-003 SHALL have parameter INIT_SEL, default 0, meaning the channel active after reset.
REQ-004 SHALL have derived localparam SEL_W = $clog2(NUM_CH) and MAXB = 2**FADE_SHIFT.
REQ-005 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port frameStart  in  1  one-cycle strobe per video frame.
REQ-008 SHALL have port selCode  in  SEL_W  requested channel, e.g. level/win/game-over screen.
REQ-009 SHALL have port drawingRequestIn  in  NUM_CH  per-channel draw request; bit i = channel i.
REQ-010 SHALL have port RGBin  in  NUM_CH*8  packed RGB332 pixels; channel i at [8i+7:8i].
REQ-011 SHALL have port drawingRequest_out  out  1  registered request of the active channel.
REQ-012 SHALL have port RGBout  out  8  registered, brightness-scaled RGB332 pixel.
REQ-013 SHALL have port activeSel  out  SEL_W  channel currently being displayed.
REQ-014 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-015 SHALL register outputs with one-clock latency: cycle N inputs appear on RGBout/drawingRequest_out at cycle N+1.
REQ-016 SHALL compute RGBout per component as (c * b) >> FADE_SHIFT, with R,G 3-bit and B 2-bit, b = brightness 0..MAXB, truncating.
REQ-017 SHALL pass drawingRequest_out = drawingRequestIn[activeSel] unchanged by brightness.
REQ-018 SHALL implement states IDLE, FADE_OUT, HOLD, FADE_IN; b changes only on frameStart.
REQ-019 SHALL, in IDLE with valid selCode != activeSel, latch target <= selCode and enter FADE_OUT on the same clock.
REQ-020 SHALL, in FADE_OUT on frameStart, decrement b; when b goes 1 -> 0, enter HOLD.
REQ-021 SHALL, in HOLD on frameStart, load activeSel <= target and enter FADE_IN with b = 0.
REQ-022 SHALL, in FADE_IN on frameStart, increment b; when b reaches MAXB, enter IDLE.
REQ-023 SHALL, during FADE_OUT and HOLD, update target from any valid selCode (last request wins).
REQ-024 SHALL, if target equals activeSel during FADE_OUT, enter FADE_IN from current b without switching.
REQ-025 SHALL, during FADE_IN, ignore selCode; a pending difference is acted on once IDLE is reached.
REQ-026 SHALL treat selCode >= NUM_CH as invalid: no state change, target unchanged.
REQ-027 SHALL never let b exceed MAXB or wrap below 0.

Reset
REQ-028 SHALL, on reset assertion, immediately set state IDLE, activeSel = target = INIT_SEL, b = MAXB, RGBout = 8'h00, drawingRequest_out = 0, busy = 0.
REQ-029 SHALL abort any transition in progress on reset; no frameStart is required to recover.

Configuration
REQ-030 SHALL honour macro SCREEN_FADE_EN: when defined, REQ-016..REQ-027 apply.
REQ-031 SHALL, without SCREEN_FADE_EN, hold b = MAXB (no scaling) and load activeSel <= valid selCode on the next clock, with busy tied 0.

Verification
REQ-032 SHALL cover reset: NUM_CH=4, INIT_SEL=0, pulse reset mid-FADE_OUT -> outputs 0, activeSel=0, busy=0, b=MAXB.
REQ-033 SHALL cover scaling: FADE_SHIFT=2, channel RGB 8'hFF, b=2 -> RGBout 8'h6D; b=0 -> 8'h00; b=4 -> 8'hFF.
REQ-034 SHALL cover full transition: FADE_SHIFT=2, selCode 0->2 -> 4 frames fade-out, 1 HOLD frame, activeSel=2, 4 frames fade-in, busy low after 9th frameStart.
REQ-035 SHALL cover retarget: selCode 0->1 then 3 during FADE_OUT -> activeSel becomes 3, never 1.
REQ-036 SHALL cover reversal: selCode 0->1 then back to 0 at b=2 -> FADE_IN from b=2, activeSel stays 0.
REQ-037 SHALL cover invalid code: NUM_CH=3, selCode=3 in IDLE -> busy stays 0, activeSel unchanged.
